// File: rtl/vga_pixel_fifo_if.sv
// Pixel FIFO bus: framebuffer-reader write side, VGA timing read side,
// plus the frame-alignment flush and the debug status outputs.
interface vga_pixel_fifo_if #(
    parameter int AW = 4
);
    logic          flush;
    logic [2:0]    wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          rd_en;
    logic [2:0]    rd_data;
    logic [AW:0]   level;
    logic [7:0]    underflow_cnt;

    // Side that drives pixels in and pulls pixels out
    modport master (
        output flush, wr_data, wr_valid, rd_en,
        input  wr_ready, rd_data, level, underflow_cnt
    );

    // The FIFO itself
    modport slave (
        input  flush, wr_data, wr_valid, rd_en,
        output wr_ready, rd_data, level, underflow_cnt
    );
endinterface

// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: single-clock 3-bit RGB pixel FIFO feeding the VGA output.
// One registered pop per active-video clock, one write per clock. Reads of an
// empty FIFO produce a fill pixel and bump a saturating debug counter. A flush
// pulse at VSYNC realigns the FIFO to the frame without clearing the counter.
// Build option: define VGA_PIXFIFO_HOLD_EN to repeat the last pixel on
// underflow instead of forcing black.
module vga_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    vga_pixel_fifo_if.slave  bus
);
    localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
    localparam logic [AW:0]   ZERO_LEVEL = {(AW + 1){1'b0}};
    localparam logic [AW:0]   ONE_LEVEL  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO_PTR   = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_PTR    = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [7:0]    UCNT_MAX   = 8'hFF;

    logic [2:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [2:0]    rd_data_r;
    logic [7:0]    ucnt_r;

    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [AW:0]   level_nxt_s;
    logic [2:0]    rd_data_nxt_s;
    logic [7:0]    ucnt_nxt_s;
    logic [2:0]    fill_pix_s;

    logic          wr_ready_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          underflow_s;

    // Handshake decode from registered occupancy only (no bypass paths)
    always_comb begin
        wr_ready_s  = (level_r != FULL_LEVEL);
        wr_acc_s    = bus.wr_valid && wr_ready_s && !bus.flush;
        rd_acc_s    = bus.rd_en && (level_r != ZERO_LEVEL) && !bus.flush;
        underflow_s = bus.rd_en && (level_r == ZERO_LEVEL) && !bus.flush;
    end

`ifdef VGA_PIXFIFO_HOLD_EN
    // Underflow repeats the last pixel shown to mask short gaps
    always_comb begin
        fill_pix_s = rd_data_r;
    end
`else
    // Underflow shows black
    always_comb begin
        fill_pix_s = 3'b000;
    end
`endif

    // Next-state for pointers, occupancy, output pixel and underflow counter
    always_comb begin
        wr_ptr_nxt_s  = wr_ptr_r;
        rd_ptr_nxt_s  = rd_ptr_r;
        level_nxt_s   = level_r;
        rd_data_nxt_s = rd_data_r;
        ucnt_nxt_s    = ucnt_r;

        if (bus.flush) begin
            // Flush wins over everything; the debug counter survives it
            wr_ptr_nxt_s  = ZERO_PTR;
            rd_ptr_nxt_s  = ZERO_PTR;
            level_nxt_s   = ZERO_LEVEL;
            rd_data_nxt_s = 3'b000;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_nxt_s = wr_ptr_r + ONE_PTR;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end

            if (rd_acc_s) begin
                rd_data_nxt_s = mem_r[rd_ptr_r];
                rd_ptr_nxt_s  = rd_ptr_r + ONE_PTR;
            end else if (underflow_s) begin
                rd_data_nxt_s = fill_pix_s;
            end else begin
                rd_data_nxt_s = rd_data_r;
            end

            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_nxt_s = level_r + ONE_LEVEL;
                2'b01:   level_nxt_s = level_r - ONE_LEVEL;
                default: level_nxt_s = level_r;
            endcase

            if (underflow_s && (ucnt_r != UCNT_MAX)) begin
                ucnt_nxt_s = ucnt_r + 8'd1;
            end else begin
                ucnt_nxt_s = ucnt_r;
            end
        end
    end

    // Pixel storage; contents are meaningless after reset so no reset term
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= ZERO_PTR;
            rd_ptr_r  <= ZERO_PTR;
            level_r   <= ZERO_LEVEL;
            rd_data_r <= 3'b000;
            ucnt_r    <= 8'd0;
        end else begin
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            level_r   <= level_nxt_s;
            rd_data_r <= rd_data_nxt_s;
            ucnt_r    <= ucnt_nxt_s;
        end
    end

    assign bus.wr_ready      = wr_ready_s;
    assign bus.rd_data       = rd_data_r;
    assign bus.level         = level_r;
    assign bus.underflow_cnt = ucnt_r;
endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo with a queue model and an expected-output
// scoreboard. Honors VGA_PIXFIFO_HOLD_EN the same way the design does.
module tb_vga_pixel_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk;
    logic rst;

    vga_pixel_fifo_if #(.AW(AW)) bus ();

    vga_pixel_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0] mdl_q [$];
    logic [2:0] exp_q [$];
    logic [2:0] mdl_rd   = 3'd0;
    int         mdl_ucnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, update model from pre-edge state, compare after edge
    task automatic step(input logic wv, input logic [2:0] wd, input logic re,
                        input logic fl, input string tag);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_en    = re;
        bus.flush    = fl;
        if (fl) begin
            mdl_q.delete();
            mdl_rd = 3'd0;
        end else begin
            rd_ok = re && (mdl_q.size() != 0);
            wr_ok = wv && (mdl_q.size() != DEPTH);
            if (rd_ok) begin
                mdl_rd = mdl_q.pop_front();
            end else if (re) begin
                if (mdl_ucnt < 255) mdl_ucnt++;
`ifndef VGA_PIXFIFO_HOLD_EN
                mdl_rd = 3'd0;
`endif
            end
            if (wr_ok) mdl_q.push_back(wd);
        end
        exp_q.push_back(mdl_rd);
        @(posedge clk);
        #1;
        check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(exp_q.pop_front()));
        check({tag, ".level"}, 32'(bus.level), 32'(mdl_q.size()));
        check({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(mdl_q.size() != DEPTH));
        check({tag, ".ucnt"}, 32'(bus.underflow_cnt), 32'(mdl_ucnt));
    endtask

    initial begin
        logic [2:0] px;
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 3'd0;
        bus.rd_en    = 1'b0;

        // Reset state
        #3;
        check("rst.rd_data", 32'(bus.rd_data), 32'd0);
        check("rst.level", 32'(bus.level), 32'd0);
        check("rst.wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rst.ucnt", 32'(bus.underflow_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill to full, then one refused write
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i % 8), 1'b0, 1'b0, "fill");
        check("fill.full_level", 32'(bus.level), 32'd16);
        check("fill.full_ready", 32'(bus.wr_ready), 32'd0);
        step(1'b1, 3'd7, 1'b0, 1'b0, "fill17");

        // Drain; first pop of a full FIFO also offers a write that must be refused
        step(1'b1, 3'd5, 1'b1, 1'b0, "drain_full");
        for (int i = 1; i < DEPTH; i++) step(1'b0, 3'd0, 1'b1, 1'b0, "drain");
        check("drain.empty", 32'(bus.level), 32'd0);

        // Streaming with one pixel preloaded
        step(1'b1, 3'd3, 1'b0, 1'b0, "preload");
        for (int i = 0; i < 1000; i++) begin
            px = 3'($urandom_range(0, 7));
            step(1'b1, px, 1'b1, 1'b0, "stream");
        end

        // Async reset between edges while streaming
        #2;
        rst = 1'b0;
        #1;
        check("arst.rd_data", 32'(bus.rd_data), 32'd0);
        check("arst.level", 32'(bus.level), 32'd0);
        check("arst.wr_ready", 32'(bus.wr_ready), 32'd1);
        check("arst.ucnt", 32'(bus.underflow_cnt), 32'd0);
        mdl_q.delete();
        mdl_rd   = 3'd0;
        mdl_ucnt = 0;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        rst          = 1'b1;
        step(1'b1, 3'd4, 1'b0, 1'b0, "resume_pre");
        for (int i = 0; i < 20; i++) step(1'b1, 3'(i + 1), 1'b1, 1'b0, "resume");
        step(1'b0, 3'd0, 1'b1, 1'b0, "resume_drain");

        // Underflow: write 5 then read 8
        for (int i = 1; i <= 5; i++) step(1'b1, 3'(i), 1'b0, 1'b0, "uf_wr");
        for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 1'b1, 1'b0, "uf_rd");
        check("uf.cnt3", 32'(bus.underflow_cnt), 32'd3);
`ifdef VGA_PIXFIFO_HOLD_EN
        check("uf.hold", 32'(bus.rd_data), 32'd5);
`else
        check("uf.black", 32'(bus.rd_data), 32'd0);
`endif

        // Flush priority with level 9, then flush on an empty FIFO with rd_en
        for (int i = 0; i < 9; i++) step(1'b1, 3'(i + 2), 1'b0, 1'b0, "fl_wr");
        check("fl.level9", 32'(bus.level), 32'd9);
        step(1'b1, 3'd3, 1'b1, 1'b1, "flush");
        step(1'b0, 3'd0, 1'b1, 1'b1, "flush_empty");

        // Write into empty is not readable in the same cycle
        step(1'b1, 3'd6, 1'b1, 1'b0, "nobypass");
        step(1'b0, 3'd0, 1'b1, 1'b0, "nobypass_rd");

        // Saturation
        for (int i = 0; i < 300; i++) step(1'b0, 3'd0, 1'b1, 1'b0, "sat");
        check("sat.255", 32'(bus.underflow_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
